// File: rtl/ysyx_22040895_lsu_pkg.sv
// Shared types for the load/store unit.
// Op/size codes, FSM states and byte-mask helper.
package ysyx_22040895_lsu_pkg;

  typedef enum logic [1:0] {
    OP_PASS  = 2'b00,
    OP_STORE = 2'b01,
    OP_LOAD  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    REQ1,
    WAIT1,
    RESP
  } state_e;

  function automatic logic [7:0] size_bmask(
    input logic [1:0] size
  );
    logic [7:0] m;
    unique case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ysyx_22040895_lsu_align.sv
// Combinational lane steering for the LSU.
// Beat masks/data on the way out, extraction on the way back.
module ysyx_22040895_lsu_align
  import ysyx_22040895_lsu_pkg::*;
#(
  parameter bit ALIGNED_ONLY = 1'b0
) (
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [2:0]  off,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata_lo,
  input  logic [63:0] rdata_hi,
  output logic        split,
  output logic [7:0]  mask0,
  output logic [7:0]  mask1,
  output logic [63:0] wdata0,
  output logic [63:0] wdata1,
  output logic [63:0] load_res
);

  logic [3:0]   nb;
  logic [15:0]  mask16;
  logic [127:0] wwide;
  logic [63:0]  raw;

  // Lane positioning over a 16-byte window spanning both beats
  always_comb begin
    nb     = 4'd1 << size;
    mask16 = {8'h00, size_bmask(size)} << off;
    split  = ALIGNED_ONLY ? 1'b0
           : (({1'b0, off} + nb) > 4'd8);
    mask0  = mask16[7:0];
    mask1  = mask16[15:8];
    wwide  = {64'h0, wdata} << {off, 3'b000};
    wdata0 = wwide[63:0];
    wdata1 = wwide[127:64];
    raw    = 64'({rdata_hi, rdata_lo}
                 >> {off, 3'b000});
    unique case (size)
      SZ_B:
        load_res = {{56{sign & raw[7]}},
                    raw[7:0]};
      SZ_H:
        load_res = {{48{sign & raw[15]}},
                    raw[15:0]};
      SZ_W:
        load_res = {{32{sign & raw[31]}},
                    raw[31:0]};
      default:
        load_res = raw;
    endcase
  end

endmodule

// File: rtl/ysyx_22040895_lsu.sv
// Load/store unit between execute and writeback.
// Splits 8-byte-crossing accesses into two beats.
module ysyx_22040895_lsu
  import ysyx_22040895_lsu_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter bit ALIGNED_ONLY = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op_i,
  input  logic [1:0]      size_i,
  input  logic            sign_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] result_i,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] wdata_o
);

  state_e            state_q, state_d;
  logic [1:0]        op_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wd_q;
  logic [XLEN-1:0]   rdata0_q;
  logic [XLEN-1:0]   base0, base1;
  logic [XLEN-1:0]   rd_lo, rd_hi;
  logic [XLEN-1:0]   wdata0, wdata1;
  logic [XLEN-1:0]   load_res;
  logic [7:0]        mask0, mask1;
  logic              split, is_mem, is_st;
  logic              accept, fin;

  assign is_mem = (op_i == OP_STORE)
               || (op_i == OP_LOAD);
  assign is_st  = (op_q == OP_STORE);
  assign base0  = {addr_q[XLEN-1:3], 3'b000};
  assign base1  = base0 + XLEN'(8);
  assign accept = in_valid && in_ready;
  assign rd_lo  = (state_q == WAIT0)
                ? mem_rdata : rdata0_q;
  assign rd_hi  = (state_q == WAIT1)
                ? mem_rdata : '0;
  assign fin    = mem_rvalid
               && (((state_q == WAIT0) && !split)
                || (state_q == WAIT1));

  ysyx_22040895_lsu_align #(
    .ALIGNED_ONLY(ALIGNED_ONLY)
  ) u_align (
    .size    (size_q),
    .sign    (sign_q),
    .off     (addr_q[2:0]),
    .wdata   (wd_q),
    .rdata_lo(rd_lo),
    .rdata_hi(rd_hi),
    .split   (split),
    .mask0   (mask0),
    .mask1   (mask1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .load_res(load_res)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake/memory outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_d = is_mem ? REQ0 : RESP;
      end
      REQ0: begin
        mem_req   = 1'b1;
        mem_we    = is_st;
        mem_addr  = base0;
        mem_wdata = wdata0;
        mem_wmask = mask0;
        if (mem_gnt) state_d = WAIT0;
      end
      WAIT0: begin
        if (mem_rvalid)
          state_d = split ? REQ1 : RESP;
      end
      REQ1: begin
        mem_req   = 1'b1;
        mem_we    = is_st;
        mem_addr  = base1;
        mem_wdata = wdata1;
        mem_wmask = mask1;
        if (mem_gnt) state_d = WAIT1;
      end
      WAIT1: begin
        if (mem_rvalid) state_d = RESP;
      end
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Op capture, first-beat data and writeback value
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_PASS;
      size_q   <= SZ_B;
      sign_q   <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      rdata0_q <= '0;
      wdata_o  <= '0;
    end else begin
      if (accept) begin
        op_q   <= op_i;
        size_q <= size_i;
        sign_q <= sign_i;
        addr_q <= addr_i;
        wd_q   <= wdata_i;
        if (!is_mem) wdata_o <= result_i;
      end
      if ((state_q == WAIT0) && mem_rvalid)
        rdata0_q <= mem_rdata;
      if (fin)
        wdata_o <= is_st ? '0 : load_res;
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
// Directed bench for the load/store unit.
// Vector table plus back-pressure and reset sequences.
module tb_ysyx_22040895_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op_i;
  logic [1:0]  size_i;
  logic        sign_i;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic [63:0] result_i;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] wdata_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ysyx_22040895_lsu dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_i      (op_i),
    .size_i    (size_i),
    .sign_i    (sign_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .result_i  (result_i),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wdata_o   (wdata_o)
  );

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  size;
    logic        sign;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] result;
    logic [63:0] rd0;
    logic [63:0] rd1;
    logic [63:0] exp;
    int          beats;
    logic [63:0] a0;
    logic [63:0] a1;
    logic [7:0]  m0;
    logic [7:0]  m1;
    logic [63:0] w0;
    logic [63:0] w1;
  } vec_t;

  vec_t vt[11];

  function automatic vec_t mk(
    input logic [1:0]  op,
    input logic [1:0]  size,
    input logic        sign,
    input logic [63:0] addr,
    input logic [63:0] wdata,
    input logic [63:0] result,
    input logic [63:0] rd0,
    input logic [63:0] rd1,
    input logic [63:0] exp,
    input int          beats,
    input logic [63:0] a0,
    input logic [63:0] a1,
    input logic [7:0]  m0,
    input logic [7:0]  m1,
    input logic [63:0] w0,
    input logic [63:0] w1
  );
    vec_t v;
    v.op = op; v.size = size; v.sign = sign;
    v.addr = addr; v.wdata = wdata;
    v.result = result; v.rd0 = rd0; v.rd1 = rd1;
    v.exp = exp; v.beats = beats;
    v.a0 = a0; v.a1 = a1; v.m0 = m0; v.m1 = m1;
    v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  task automatic drive_op(
    input logic [1:0]  op,
    input logic [1:0]  size,
    input logic        sign,
    input logic [63:0] addr,
    input logic [63:0] wdata,
    input logic [63:0] result
  );
    in_valid = 1'b1;
    op_i     = op;
    size_i   = size;
    sign_i   = sign;
    addr_i   = addr;
    wdata_i  = wdata;
    result_i = result;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    string p;
    p = $sformatf("v%0d", k);
    @(negedge clk);
    chk({p, " in_ready idle"}, 64'(in_ready), 64'd1);
    drive_op(v.op, v.size, v.sign,
             v.addr, v.wdata, v.result);
    @(negedge clk);
    in_valid = 1'b0;
    for (int b = 0; b < v.beats; b++) begin
      chk({p, " mem_req"}, 64'(mem_req), 64'd1);
      chk({p, " in_ready busy"}, 64'(in_ready), 64'd0);
      chk({p, " mem_addr"}, mem_addr,
          (b == 0) ? v.a0 : v.a1);
      chk({p, " mem_wmask"}, 64'(mem_wmask),
          64'((b == 0) ? v.m0 : v.m1));
      chk({p, " mem_we"}, 64'(mem_we),
          64'(v.op == 2'b01));
      if (v.op == 2'b01)
        chk({p, " mem_wdata"}, mem_wdata,
            (b == 0) ? v.w0 : v.w1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk({p, " mem_req drop"}, 64'(mem_req), 64'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = (b == 0) ? v.rd0 : v.rd1;
      @(negedge clk);
      mem_rvalid = 1'b0;
    end
    chk({p, " out_valid"}, 64'(out_valid), 64'd1);
    chk({p, " no mem_req"}, 64'(mem_req), 64'd0);
    chk({p, " wdata_o"}, wdata_o, v.exp);
  endtask

  initial begin
    logic [63:0] a_s;
    rst        = 1'b1;
    in_valid   = 1'b0;
    op_i       = 2'b00;
    size_i     = 2'b00;
    sign_i     = 1'b0;
    addr_i     = '0;
    wdata_i    = '0;
    result_i   = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    out_ready  = 1'b1;

    vt[0]  = mk(2'b00, 2'b00, 1'b0, 64'h0, 64'h0,
                64'h1234, 64'h0, 64'h0, 64'h1234, 0,
                64'h0, 64'h0, 8'h0, 8'h0, 64'h0, 64'h0);
    vt[1]  = mk(2'b10, 2'b00, 1'b1, 64'h8000_0003, 64'h0,
                64'h0, 64'h0000_0000_8100_0000, 64'h0,
                64'hFFFF_FFFF_FFFF_FF81, 1,
                64'h8000_0000, 64'h0, 8'h08, 8'h0,
                64'h0, 64'h0);
    vt[2]  = mk(2'b10, 2'b00, 1'b0, 64'h8000_0003, 64'h0,
                64'h0, 64'h0000_0000_8100_0000, 64'h0,
                64'h81, 1,
                64'h8000_0000, 64'h0, 8'h08, 8'h0,
                64'h0, 64'h0);
    vt[3]  = mk(2'b01, 2'b01, 1'b0, 64'h8000_0006, 64'hBEEF,
                64'h0, 64'h0, 64'h0, 64'h0, 1,
                64'h8000_0000, 64'h0, 8'hC0, 8'h0,
                64'hBEEF_0000_0000_0000, 64'h0);
    vt[4]  = mk(2'b10, 2'b10, 1'b0, 64'h8000_0006, 64'h0,
                64'h0, 64'hDDCC_1122_3344_5566,
                64'h7788_99EE_FF00_BBAA,
                64'hBBAA_DDCC, 2,
                64'h8000_0000, 64'h8000_0008, 8'hC0, 8'h03,
                64'h0, 64'h0);
    vt[5]  = mk(2'b10, 2'b11, 1'b1, 64'h1000, 64'h0,
                64'h0, 64'h8877_6655_4433_2211, 64'h0,
                64'h8877_6655_4433_2211, 1,
                64'h1000, 64'h0, 8'hFF, 8'h0,
                64'h0, 64'h0);
    vt[6]  = mk(2'b10, 2'b01, 1'b1, 64'h2002, 64'h0,
                64'h0, 64'h0000_0000_F00D_0000, 64'h0,
                64'hFFFF_FFFF_FFFF_F00D, 1,
                64'h2000, 64'h0, 8'h0C, 8'h0,
                64'h0, 64'h0);
    vt[7]  = mk(2'b01, 2'b11, 1'b0, 64'h3005,
                64'h1122_3344_5566_7788,
                64'h0, 64'h0, 64'h0, 64'h0, 2,
                64'h3000, 64'h3008, 8'hE0, 8'h1F,
                64'h6677_8800_0000_0000,
                64'h0000_0011_2233_4455);
    vt[8]  = mk(2'b10, 2'b10, 1'b1, 64'h4004, 64'h0,
                64'h0, 64'h8000_0001_DEAD_BEEF, 64'h0,
                64'hFFFF_FFFF_8000_0001, 1,
                64'h4000, 64'h0, 8'hF0, 8'h0,
                64'h0, 64'h0);
    vt[9]  = mk(2'b10, 2'b01, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0,
                64'hAB00_0000_0000_0000,
                64'h0000_0000_0000_00CD,
                64'hCDAB, 2,
                64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 8'h80, 8'h01,
                64'h0, 64'h0);
    vt[10] = mk(2'b11, 2'b10, 1'b1, 64'h10, 64'h0,
                64'hCAFE, 64'h0, 64'h0, 64'hCAFE, 0,
                64'h0, 64'h0, 8'h0, 8'h0, 64'h0, 64'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst mem_req", 64'(mem_req), 64'd0);
    chk("rst mem_we", 64'(mem_we), 64'd0);
    chk("rst mem_addr", mem_addr, 64'd0);
    chk("rst mem_wdata", mem_wdata, 64'd0);
    chk("rst mem_wmask", 64'(mem_wmask), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst wdata_o", wdata_o, 64'd0);
    rst = 1'b0;

    for (int k = 0; k < 11; k++) run_vec(vt[k], k);

    // Back-pressure on both gnt and out_ready
    @(negedge clk);
    drive_op(2'b10, 2'b10, 1'b0, 64'h5000,
             64'h0, 64'h0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp mem_req", 64'(mem_req), 64'd1);
      chk("bp mem_addr", mem_addr, 64'h5000);
      chk("bp mem_wmask", 64'(mem_wmask), 64'h0F);
      chk("bp mem_we", 64'(mem_we), 64'd0);
      chk("bp in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hAAAA_BBBB_1234_5678;
    out_ready  = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp out_valid", 64'(out_valid), 64'd1);
      chk("bp wdata_o", wdata_o, 64'h1234_5678);
      chk("bp resp in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    drive_op(2'b00, 2'b00, 1'b0, 64'h0,
             64'h0, 64'h77);
    @(negedge clk);
    chk("bp idle out_valid", 64'(out_valid), 64'd0);
    chk("bp idle in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp next out_valid", 64'(out_valid), 64'd1);
    chk("bp next wdata_o", wdata_o, 64'h77);

    // Reset while waiting on the second beat
    @(negedge clk);
    drive_op(2'b10, 2'b10, 1'b0, 64'h8000_0006,
             64'h0, 64'h0);
    @(negedge clk);
    in_valid = 1'b0;
    mem_gnt  = 1'b1;
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h1111_2222_3333_4444;
    @(negedge clk);
    mem_rvalid = 1'b0;
    a_s = mem_addr;
    chk("rs beat1 addr", a_s, 64'h8000_0008);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rs mem_req", 64'(mem_req), 64'd0);
    chk("rs out_valid", 64'(out_valid), 64'd0);
    chk("rs in_ready", 64'(in_ready), 64'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h5555_6666_7777_8888;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rs late out_valid", 64'(out_valid), 64'd0);
    chk("rs late mem_req", 64'(mem_req), 64'd0);
    chk("rs late in_ready", 64'(in_ready), 64'd1);
    run_vec(vt[1], 11);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ysyx_22040895_lsu.md
Name: ysyx_22040895_lsu

Overview:
Load/store unit that sits directly upstream of the core's memory interface, between execute and writeback. It takes one memory op per handshake and drives a req/gnt + rvalid data-memory port. It splits accesses that cross an 8-byte boundary into two aligned beats. It then aligns and sign/zero-extends load data and presents the writeback value on a valid/ready output. Non-memory ops pass through with one cycle of latency.

Parameters:
XLEN, 64, datapath width (only 64 supported)
ALIGNED_ONLY, 0, 1 = misaligned crossing access is never split (bench/debug only; unsplit result undefined)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
in_valid  in  1  execute presents an op
in_ready  out  1  LSU can accept (high only in IDLE)
op_i  in  2  00 pass, 01 store, 10 load, 11 reserved (treated as pass)
size_i  in  2  00 byte, 01 half, 10 word, 11 double
sign_i  in  1  load sign-extend (1) / zero-extend (0)
addr_i  in  64  byte address (ALU result)
wdata_i  in  64  store data, LSB-justified
result_i  in  64  ALU result forwarded for pass ops
mem_req  out  1  memory request valid
mem_gnt  in  1  request accepted this cycle
mem_we  out  1  1 = write
mem_addr  out  64  8-byte-aligned address
mem_wdata  out  64  lane-positioned write data
mem_wmask  out  8  byte enables
mem_rvalid  in  1  response (read data or write ack), one per granted req
mem_rdata  in  64  read data, valid with mem_rvalid
out_valid  out  1  writeback data valid
out_ready  in  1  writeback accepts
wdata_o  out  64  value for the register file

Behaviour:
- Reset: state IDLE; in_ready=1; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0; out_valid=0, wdata_o=0. Reset mid-operation aborts it, and no retry follows. Any mem_rvalid arriving in IDLE is ignored.
- Accept occurs on in_valid&&in_ready. All inputs are latched. off=addr[2:0], nb=1<<size, split=(off+nb>8).
- Beat0: addr={addr[63:3],3'b0}, mask=((1<<nb)-1)<<off [7:0], wdata=wdata_i<<(8*off).
- Beat1, when split: addr = beat0 addr + 8 (wraps mod 2^64), mask=(((1<<nb)-1)<<off)[15:8], wdata=wdata_i>>(8*(8-off)).
- States:
  - IDLE. Pass op goes to RESP with wdata_o=result_i. Load/store goes to REQ0.
  - REQ0. mem_req=1. Fields hold stable until mem_gnt, then go to WAIT0.
  - WAIT0. On mem_rvalid, capture rdata0. Go to REQ1 if split, else to RESP.
  - REQ1 and WAIT1. Same as REQ0/WAIT0 for beat1, capturing rdata1, then go to RESP.
  - RESP. out_valid=1. wdata_o is held stable until out_ready, then go to IDLE.
- mem_req is deasserted in the cycle after gnt; one outstanding request max. gnt and rvalid may arrive in the same cycle as req only if the memory allows it; the LSU still waits for rvalid in WAIT.
- Load result: raw={rdata1,rdata0}>>(8*off) (rdata1=0 if not split). Take the low 8*nb bits and sign/zero-extend per sign_i. Double ignores sign_i.
- Store result: wdata_o=0; out_valid is still raised so writeback retires in order.
- Minimum latency, accept to out_valid: pass 1 cycle; aligned load/store with gnt same cycle and rvalid next cycle, 3 cycles; split access, 5 cycles.
- in_ready=0 in every state except IDLE. A new op is accepted the cycle after the RESP handshake, never in the same cycle.

Decomposition:
- Package ysyx_22040895_lsu_pkg: op codes, size codes, state enum (IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP), and a size-to-bytemask function.
- Sub-module ysyx_22040895_lsu_align: purely combinational. It computes split, beat masks, shifted write data, and load extraction/extension. The FSM stays in the top module.

Test Plan:
- Pass op, result_i=0x1234, out_ready=1 -> out_valid one cycle after accept, wdata_o=0x1234, no mem_req.
- Load byte signed at addr 0x80000003, rdata0=0x0000_0000_8100_0000 -> mem_addr=0x80000000, mem_wmask=0x08, wdata_o=0xFFFF_FFFF_FFFF_FF81. The same with sign_i=0 -> 0x81.
- Store half 0xBEEF at 0x80000006 -> one beat, mem_wmask=0xC0, mem_wdata=0xBEEF_0000_0000_0000, mem_we=1; out_valid after ack with wdata_o=0.
- Load word at 0x80000006, rdata0=0xDDCC_xxxx_xxxx_xxxx, rdata1=0x...._BBAA -> two beats (0x80000000 mask 0xC0, 0x80000008 mask 0x03), sign_i=0 -> wdata_o=0xBBAA_DDCC.
- Back-pressure: hold mem_gnt=0 for 4 cycles, then hold out_ready=0 for 3 cycles -> mem_req and all mem fields stable, in_ready=0 throughout, wdata_o stable until the handshake.
- Reset asserted in WAIT1 -> next cycle IDLE, mem_req=0, out_valid=0. A late mem_rvalid is ignored, and the next load completes correctly.
